dpram_reader: RTL and testbench
===============================

# dpram_reader

Read-side engine for the 256×16 DPRAM sample buffer in the MEMS capture path. Once started, it reads a contiguous run of words from the buffer's read port, wrapping at the end of the buffer. It absorbs the RAM's one-cycle read latency and presents the words as a valid/ready stream with a last-word flag. It pairs with the write-pulse generator that fills the buffer, and feeds downstream framing/serialisation logic.

## Interface

Parameters:
- AW, 8, RAM address width; buffer depth is 2^AW.
- DW, 16, RAM data width.

Ports:
- ck, in, 1, sole clock; all logic on posedge.
- rst_n, in, 1, reset; synchronous, active-low.
- start, in, 1, one-cycle request to begin a burst; ignored while busy.
- base_addr, in, AW, first address of the burst; sampled with start.
- count, in, AW+1, number of words to read, 0..2^AW; sampled with start.
- busy, out, 1, burst in progress.
- done, out, 1, one-cycle pulse at burst completion.
- raddr, out, AW, to RAM raddr.
- re, out, 1, to RAM re; the instantiator ties RAM rclke high.
- rdata, in, DW, from RAM rdata; valid the cycle after re.
- out_data, out, DW, stream data.
- out_last, out, 1, marks the final word of the burst.
- out_valid, out, 1, stream valid.
- out_ready, in, 1, downstream accept.

## Operation

- **States:**
  - IDLE: waiting for start.
  - RUN: issuing reads and draining words.
  - FLUSH: all reads issued; draining the remaining words.
- **IDLE → RUN:** start=1 and count≠0.
  - Latch next_addr=base_addr and remaining=count.
- **IDLE, start with count=0:** no reads are issued. done pulses the next cycle and busy stays 0.
- **Read issue in RUN:**
  - re=1 when remaining≠0 and credit is available.
  - Credit is available when fifo_occupancy + inflight − pop < 2, where pop = out_valid & out_ready in the same cycle.
  - Each issued read: raddr=next_addr, then next_addr+1 mod 2^AW and remaining−1.
- **RUN → FLUSH:** when remaining reaches 0.
- **FLUSH → IDLE:** on the handshake of the word with out_last=1. done pulses the following cycle.
- **Data path:**
  - inflight is a 1-bit flag set by re.
  - The cycle after re, rdata is pushed into a 2-entry FIFO, together with a last bit. last = 1 when that read was issued with remaining=1.
- **Output:** out_valid = FIFO non-empty. out_data and out_last come from the FIFO head.
- **Ordering:** words are output in address order. No word is dropped or duplicated under any out_ready pattern.
- **Overflow:** the credit rule guarantees the FIFO never overflows.
- **start while busy:** ignored; it has no effect on the latched parameters.
- **Wrap-around:** base_addr=0xFE with count=4 reads addresses 0xFE, 0xFF, 0x00, 0x01.
- **count=256:** reads every word once, starting at base_addr.
- **Reset:** rst_n=0 at any point, including mid-burst, returns to IDLE and flushes the FIFO. Any in-flight read is discarded.
- **Reset values:** busy=0, done=0, re=0, raddr=0, out_valid=0, out_last=0, out_data=0.

## Timing

- Cycle 0: start sampled.
- Cycle 1: busy=1, re=1, raddr=base_addr.
- Cycle 2: rdata valid; pushed into the FIFO at the end of the cycle.
- Cycle 3: out_valid=1 with word 0. Latency from start to first word is 3 cycles.
- **Throughput:** with out_ready held high, one word per cycle. A burst of N words has its last handshake at cycle N+2.
- **Completion:** done=1 and busy=0 in the cycle after the last handshake; the next start is accepted in that same cycle.
- **Backpressure:** with out_ready=0 the FIFO holds at most 2 words and re stays 0. When out_ready rises, re may assert in that same cycle.
- **Stream rule:** out_data and out_last stay stable while out_valid=1 and out_ready=0.

## Structure

- **Package `dpram_pkg`:**
  - AW and DW defaults.
  - Depth constant 2^AW.
  - State encoding constants for IDLE, RUN and FLUSH.
- **Sub-module `fifo2`:** 2-entry synchronous FIFO, width DW+1, with push, pop, full, empty and occupancy outputs, using the same ck and rst_n. The reader instantiates it once.
- **Top level:** the FSM, address/count logic and credit logic live in `dpram_reader`.

## Test plan

- **Basic burst:** RAM preloaded with ram[i]=i×3; start with base_addr=0x10, count=4, out_ready=1.
  - Required: words 0x30, 0x33, 0x36, 0x39 on cycles 3–6.
  - out_last only on 0x39; done at cycle 7.
- **Wrap-around:** base_addr=0xFE, count=4.
  - Required: raddr sequence 0xFE, 0xFF, 0x00, 0x01; data matches in order.
- **Backpressure:** count=16 with out_ready randomly toggled at 50%.
  - Required: all 16 words delivered in order, none duplicated.
  - re never asserted while FIFO occupancy plus inflight would exceed 2.
- **Degenerate counts:**
  - count=0 → no re, done one cycle after start, busy stays 0.
  - count=256 → each address read exactly once.
- **Reset mid-burst:** rst_n=0 at cycle 5 of a 10-word burst.
  - Required: next cycle busy=0, out_valid=0, re=0.
  - A new start afterwards behaves as in the basic burst.
- **start while busy:** pulse start with different base_addr/count during a burst.
  - Required: ignored; the original burst completes unchanged.

Source files
------------

// File: rtl/dpram_pkg.sv
// Shared constants and state encoding for the DPRAM read-side engine.
// Imported by dpram_reader and its output FIFO.
package dpram_pkg;

  localparam int AW_DEF    = 8;
  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 1 << AW_DEF;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } rd_state_t;

  // Even parity over a stream word, for designs that carry a parity bit alongside.
  function automatic logic word_parity(input logic [DW_DEF:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/dpram_reader_fifo2.sv
// Two-entry synchronous FIFO that buffers RAM read data (plus a last flag)
// between the one-cycle-latency read port and the valid/ready stream.
module fifo2
  import dpram_pkg::*;
#(
  parameter int W = DW_DEF + 1
) (
  input  logic         ck,
  input  logic         rst_n,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic         o_full,
  output logic         o_empty,
  output logic [1:0]   o_occ
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_occ;
  logic         w_do_push;
  logic         w_do_pop;

  assign w_do_pop  = i_pop && (r_occ != 2'd0);
  assign w_do_push = i_push && ((r_occ != 2'd2) || w_do_pop);

  // Storage, pointers and occupancy; a pop frees its slot for a push in the same cycle.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_full  = (r_occ == 2'd2);
  assign o_empty = (r_occ == 2'd0);
  assign o_occ   = r_occ;

endmodule

// File: rtl/dpram_reader.sv
// Read-side burst engine for the DPRAM sample buffer: issues wrapping reads,
// absorbs the RAM read latency and presents words as a valid/ready stream.
module dpram_reader
  import dpram_pkg::*;
#(
  parameter int AW = AW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic          ck,
  input  logic          rst_n,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   count,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] raddr,
  output logic          re,
  input  logic [DW-1:0] rdata,
  output logic [DW-1:0] out_data,
  output logic          out_last,
  output logic          out_valid,
  input  logic          out_ready
);

  localparam logic [AW:0]   REM_ONE  = {{AW{1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_ONE = {{(AW-1){1'b0}}, 1'b1};

  rd_state_t   r_state;
  logic [AW-1:0] r_next_addr;
  logic [AW:0]   r_remaining;
  logic          r_inflight;
  logic          r_inflight_last;
  logic          r_done;

  logic [DW:0]   w_head;
  logic [1:0]    w_occ;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_credit;
  logic          w_re;
  logic          w_issue_last;

  assign w_pop        = !w_empty && out_ready;
  assign w_issue_last = (r_remaining == REM_ONE);

  // Credit: FIFO words plus the in-flight read, less this cycle's pop, must stay below two.
  always_comb begin
    w_credit = 1'b0;
    if (w_full) begin
      w_credit = w_pop && !r_inflight;
    end else if (r_inflight) begin
      w_credit = (w_occ == 2'd0) || w_pop;
    end else begin
      w_credit = 1'b1;
    end
  end

  assign w_re = (r_state == ST_RUN) && (r_remaining != '0) && w_credit;

  fifo2 #(
    .W(DW + 1)
  ) u_fifo (
    .ck      (ck),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_pop   (w_pop),
    .i_data  ({r_inflight_last, rdata}),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_occ   (w_occ)
  );

  // Burst FSM with address/count bookkeeping and the completion pulse.
  always_ff @(posedge ck) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_next_addr     <= '0;
      r_remaining     <= '0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_done          <= 1'b0;
      r_inflight      <= w_re;
      r_inflight_last <= w_re && w_issue_last;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (count != '0) begin
              r_state     <= ST_RUN;
              r_next_addr <= base_addr;
              r_remaining <= count;
            end else begin
              r_done <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (w_re) begin
            r_next_addr <= r_next_addr + ADDR_ONE;
            r_remaining <= r_remaining - REM_ONE;
            if (w_issue_last) begin
              r_state <= ST_FLUSH;
            end
          end
        end
        ST_FLUSH: begin
          // The word tagged last can only drain once every read has been issued.
          if (w_pop && w_head[DW]) begin
            r_state <= ST_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy      = (r_state != ST_IDLE);
  assign done      = r_done;
  assign raddr     = r_next_addr;
  assign re        = w_re;
  assign out_data  = w_head[DW-1:0];
  assign out_last  = w_head[DW];
  assign out_valid = !w_empty;

endmodule

// File: tb/tb_dpram_reader.sv
// Self-checking bench for dpram_reader: RAM model, expected-word scoreboard
// built from burst parameters, and a per-cycle stream/credit monitor.
module tb_dpram_reader;

  logic        ck;
  logic        rst_n;
  logic        start;
  logic [7:0]  base_addr;
  logic [8:0]  count;
  logic        busy;
  logic        done;
  logic [7:0]  raddr;
  logic        re;
  logic [15:0] rdata;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_valid;
  logic        out_ready;

  logic [15:0] ram [256];
  logic [7:0]  exp_addr_q [$];
  logic [16:0] exp_word_q [$];
  int          total;
  int          bad;
  int          issued;
  int          accepted;
  int          rd_hits [256];
  bit          prev_hold;
  logic [16:0] prev_word;
  logic [16:0] mon_word;
  bit          pop_now;

  dpram_reader dut (
    .ck        (ck),
    .rst_n     (rst_n),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .raddr     (raddr),
    .re        (re),
    .rdata     (rdata),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  // Synchronous-read RAM: data appears the cycle after re.
  always @(posedge ck) begin
    if (re) rdata <= ram[raddr];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Stream monitor: read addresses, credit limit, ordering and hold-while-stalled.
  always @(negedge ck) begin
    if (!rst_n) begin
      exp_addr_q.delete();
      exp_word_q.delete();
      issued    = 0;
      accepted  = 0;
      prev_hold = 1'b0;
    end else begin
      pop_now = out_valid && out_ready;
      if (prev_hold) begin
        check("hold_valid", {31'd0, out_valid}, 32'd1);
        check("hold_word", {15'd0, out_last, out_data}, {15'd0, prev_word});
      end
      if (re) begin
        if (exp_addr_q.size() == 0) check("spurious_re", 32'd1, 32'd0);
        else check("raddr", {24'd0, raddr}, {24'd0, exp_addr_q.pop_front()});
        check("credit", {31'd0, (issued - accepted - int'(pop_now)) < 2}, 32'd1);
        rd_hits[raddr]++;
      end
      if (pop_now) begin
        if (exp_word_q.size() == 0) begin
          check("extra_word", 32'd1, 32'd0);
        end else begin
          mon_word = exp_word_q.pop_front();
          check("data", {16'd0, out_data}, {16'd0, mon_word[15:0]});
          check("last", {31'd0, out_last}, {31'd0, mon_word[16]});
        end
      end
      if (re) issued++;
      if (pop_now) accepted++;
      prev_hold = out_valid && !out_ready;
      prev_word = {out_last, out_data};
    end
  end

  task automatic do_start(input logic [7:0] base, input logic [8:0] cnt, input bit accept);
    logic [7:0] a;
    @(posedge ck);
    #1;
    start     = 1'b1;
    base_addr = base;
    count     = cnt;
    out_ready = 1'b1;
    @(posedge ck);
    if (accept) begin
      for (int i = 0; i < int'(cnt); i++) begin
        a = 8'(int'(base) + i);
        exp_addr_q.push_back(a);
        exp_word_q.push_back({(i == int'(cnt) - 1), ram[a]});
      end
    end
    #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int n;
    bit seen;
    n    = 0;
    seen = 1'b0;
    while (!seen && n < budget) begin
      @(posedge ck);
      #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      @(negedge ck);
      if (done) seen = 1'b1;
      n++;
    end
    check("done_seen", {31'd0, seen}, 32'd1);
    if (seen) check("idle_at_done", {31'd0, busy}, 32'd0);
    check("drained", exp_word_q.size(), 32'd0);
  endtask

  task automatic basic_burst(input logic [7:0] base);
    do_start(base, 9'd4, 1'b1);
    for (int c = 1; c <= 8; c++) begin
      @(negedge ck);
      if (c == 1) begin
        check("c1_re", {31'd0, re}, 32'd1);
        check("c1_raddr", {24'd0, raddr}, {24'd0, base});
      end
      check("basic_busy", {31'd0, busy}, {31'd0, (c >= 1 && c <= 6)});
      check("basic_valid", {31'd0, out_valid}, {31'd0, (c >= 3 && c <= 6)});
      check("basic_done", {31'd0, done}, {31'd0, (c == 7)});
      if (c >= 3 && c <= 6) begin
        check("basic_data", {16'd0, out_data}, 32'(int'(base) * 3 + (c - 3) * 3));
        check("basic_last", {31'd0, out_last}, {31'd0, (c == 6)});
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int badhits;
    logic [7:0] rb;
    logic [8:0] rc;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    start     = 1'b0;
    base_addr = 8'd0;
    count     = 9'd0;
    out_ready = 1'b0;
    rdata     = 16'd0;
    for (int i = 0; i < 256; i++) begin
      ram[i]     = 16'(i * 3);
      rd_hits[i] = 0;
    end

    repeat (3) @(posedge ck);
    @(negedge ck);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_re", {31'd0, re}, 32'd0);
    check("rst_raddr", {24'd0, raddr}, 32'd0);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_last", {31'd0, out_last}, 32'd0);
    check("rst_data", {16'd0, out_data}, 32'd0);
    @(posedge ck);
    #1 rst_n = 1'b1;

    basic_burst(8'h10);

    do_start(8'hFE, 9'd4, 1'b1);
    wait_done(40, 1'b0);

    do_start(8'h55, 9'd0, 1'b1);
    @(negedge ck);
    check("zero_done", {31'd0, done}, 32'd1);
    check("zero_busy", {31'd0, busy}, 32'd0);
    check("zero_re", {31'd0, re}, 32'd0);
    @(negedge ck);
    check("zero_done_once", {31'd0, done}, 32'd0);
    check("zero_busy2", {31'd0, busy}, 32'd0);

    do_start(8'h23, 9'd16, 1'b1);
    wait_done(300, 1'b1);

    for (int i = 0; i < 256; i++) rd_hits[i] = 0;
    do_start(8'h37, 9'd256, 1'b1);
    wait_done(400, 1'b0);
    badhits = 0;
    for (int i = 0; i < 256; i++) if (rd_hits[i] != 1) badhits++;
    check("each_addr_once", badhits, 32'd0);

    do_start(8'h20, 9'd10, 1'b1);
    repeat (4) @(posedge ck);
    #1 rst_n = 1'b0;
    @(negedge ck);
    @(negedge ck);
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_re", {31'd0, re}, 32'd0);
    check("midrst_done", {31'd0, done}, 32'd0);
    @(posedge ck);
    #1 rst_n = 1'b1;
    basic_burst(8'h10);

    do_start(8'h40, 9'd6, 1'b1);
    @(posedge ck);
    #1;
    start     = 1'b1;
    base_addr = 8'h80;
    count     = 9'd3;
    @(negedge ck);
    check("busy_at_restart", {31'd0, busy}, 32'd1);
    @(posedge ck);
    #1 start = 1'b0;
    wait_done(100, 1'b1);

    for (int k = 0; k < 6; k++) begin
      rb = 8'($urandom_range(0, 255));
      rc = 9'($urandom_range(1, 40));
      do_start(rb, rc, 1'b1);
      wait_done(int'(rc) * 12 + 20, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
